// File: rtl/pdm_eth_pkg.sv
// Shared definitions for the PDM-to-Ethernet streaming path.
// Optional build macro: PDM_ARB_CHANNEL_TAG_EN adds a one-beat channel tag
// header at the start of every packet.
package pdm_eth_pkg;

  // Defaults shared with the packet generator so payload lengths line up.
  localparam int PDM_DATA_WIDTH   = 32;
  localparam int PDM_PACKET_WORDS = 64;

  // Marker byte in the tag header beat.
  localparam logic [7:0] TAG_MAGIC = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
`ifdef PDM_ARB_CHANNEL_TAG_EN
    ST_TAG  = 2'd1,
`endif
    ST_XFER = 2'd2
  } arb_state_e;

  // Channel index width, kept at least one bit so a single-channel build
  // still has a legal vector.
  function automatic int ch_bits(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Header beat layout: magic, channel, running packet count.
  function automatic logic [31:0] tag_word(input logic [7:0] ch,
                                           input logic [15:0] cnt);
    return {TAG_MAGIC, ch, cnt};
  endfunction

endpackage

// File: rtl/pdm_stream_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority selector.
// The search starts one past last_grant and wraps; the nearest asserted
// request wins. Kept standalone so the MAC-level arbiter can reuse it.
module rr_pick #(
  parameter int NUM_CH  = 4,
  parameter int CH_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0]  req,
  input  logic [CH_BITS-1:0] last_grant,
  output logic [CH_BITS-1:0] winner,
  output logic               any_req
);

  // Walk offsets from farthest to nearest so the nearest requester is the
  // last assignment and therefore the winner.
  always_comb begin
    logic [CH_BITS-1:0] idx;
    idx     = '0;
    winner  = '0;
    any_req = 1'b0;
    for (int off = NUM_CH; off >= 1; off--) begin
      idx = CH_BITS'((int'(last_grant) + off) % NUM_CH);
      if (req[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pdm_stream_arbiter.sv
// pdm_stream_arbiter: round-robin packet arbiter from NUM_CH PDM channel
// AXI-Stream sources onto the single packet generator input. Each grant
// forwards exactly PACKET_WORDS beats and marks the last one with tlast.
// The data path is a zero-latency pass-through of the granted channel;
// arbitration costs one idle cycle per packet.
// Optional build macro: PDM_ARB_CHANNEL_TAG_EN inserts a header beat
// {A5, channel, pkt_count} as beat 0 of every packet.
module pdm_stream_arbiter
  import pdm_eth_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DATA_WIDTH   = PDM_DATA_WIDTH,
  parameter int PACKET_WORDS = PDM_PACKET_WORDS,
  parameter int CH_BITS      = ch_bits(NUM_CH)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_axis_tdata_i,
  input  logic [NUM_CH-1:0]            s_axis_tvalid_i,
  output logic [NUM_CH-1:0]            s_axis_tready_o,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata_o,
  output logic                         m_axis_tvalid_o,
  output logic                         m_axis_tlast_o,
  input  logic                         m_axis_tready_i,
  output logic [CH_BITS-1:0]           grant_o,
  output logic                         busy_o,
  output logic [15:0]                  pkt_count_o
);

  localparam int CNT_W = $clog2(PACKET_WORDS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PACKET_WORDS - 1);

  arb_state_e          state_q;
  logic [CH_BITS-1:0]  grant_q;
  logic [CH_BITS-1:0]  last_grant_q;
  logic [CNT_W-1:0]    beat_cnt_q;
  logic [15:0]         pkt_count_q;

  logic [CH_BITS-1:0]  pick_winner;
  logic                pick_any;
  logic                last_beat;
  logic                out_hs;

  logic [DATA_WIDTH-1:0] ch_data [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign ch_data[g] = s_axis_tdata_i[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(
    .NUM_CH  (NUM_CH),
    .CH_BITS (CH_BITS)
  ) u_rr_pick (
    .req        (s_axis_tvalid_i),
    .last_grant (last_grant_q),
    .winner     (pick_winner),
    .any_req    (pick_any)
  );

  assign last_beat = (beat_cnt_q == LAST_BEAT);
  assign out_hs    = m_axis_tvalid_o && m_axis_tready_i;

  // Output mux: pass the granted channel straight through in XFER, drive the
  // header beat in TAG, and keep everything quiet in IDLE.
  always_comb begin
    m_axis_tdata_o  = '0;
    m_axis_tvalid_o = 1'b0;
    m_axis_tlast_o  = 1'b0;
    s_axis_tready_o = '0;
    case (state_q)
      ST_XFER: begin
        m_axis_tdata_o           = ch_data[grant_q];
        m_axis_tvalid_o          = s_axis_tvalid_i[grant_q];
        s_axis_tready_o[grant_q] = m_axis_tready_i;
        m_axis_tlast_o           = last_beat && s_axis_tvalid_i[grant_q];
      end
`ifdef PDM_ARB_CHANNEL_TAG_EN
      ST_TAG: begin
        m_axis_tdata_o  = DATA_WIDTH'(tag_word(8'(grant_q), pkt_count_q));
        m_axis_tvalid_o = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Packet FSM: pick a channel in IDLE, then count handshakes until the
  // tlast beat, at which point the round-robin pointer advances.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= CH_BITS'(NUM_CH - 1);
      beat_cnt_q   <= '0;
      pkt_count_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            grant_q <= pick_winner;
`ifdef PDM_ARB_CHANNEL_TAG_EN
            state_q <= ST_TAG;
`else
            state_q <= ST_XFER;
`endif
          end
        end
`ifdef PDM_ARB_CHANNEL_TAG_EN
        ST_TAG: begin
          if (m_axis_tready_i) begin
            beat_cnt_q <= CNT_W'(1);
            state_q    <= ST_XFER;
          end
        end
`endif
        ST_XFER: begin
          if (out_hs) begin
            if (last_beat) begin
              beat_cnt_q   <= '0;
              last_grant_q <= grant_q;
              pkt_count_q  <= pkt_count_q + 16'd1;
              state_q      <= ST_IDLE;
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant_o     = grant_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign pkt_count_o = pkt_count_q;

endmodule

// File: tb/tb_pdm_stream_arbiter.sv
// Directed bench for pdm_stream_arbiter (NUM_CH=4, DATA_WIDTH=32,
// PACKET_WORDS=64). Each source emits {channel, 24-bit sequence}; a monitor
// scoreboards every output beat against per-channel expected sequences and
// tracks beat position for tlast.
module tb_pdm_stream_arbiter;

  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int NW  = 64;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [NCH*DW-1:0] s_axis_tdata_i;
  logic [NCH-1:0]   s_axis_tvalid_i;
  logic [NCH-1:0]   s_axis_tready_o;
  logic [DW-1:0]    m_axis_tdata_o;
  logic             m_axis_tvalid_o;
  logic             m_axis_tlast_o;
  logic             m_axis_tready_i;
  logic [1:0]       grant_o;
  logic             busy_o;
  logic [15:0]      pkt_count_o;

  int n_tests = 0;
  int n_fail  = 0;

  int unsigned src_seq [NCH] = '{0, 0, 0, 0};
  int unsigned exp_seq [NCH] = '{0, 0, 0, 0};
  int          mon_beat = 0;
  int unsigned exp_pkt  = 0;
  logic [1:0]  grant_log [$];
  logic        stall_pend = 1'b0;
  logic [DW-1:0] stall_data = '0;

  always #5 clk_i = ~clk_i;

  pdm_stream_arbiter #(
    .NUM_CH       (NCH),
    .DATA_WIDTH   (DW),
    .PACKET_WORDS (NW)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .s_axis_tdata_i  (s_axis_tdata_i),
    .s_axis_tvalid_i (s_axis_tvalid_i),
    .s_axis_tready_o (s_axis_tready_o),
    .m_axis_tdata_o  (m_axis_tdata_o),
    .m_axis_tvalid_o (m_axis_tvalid_o),
    .m_axis_tlast_o  (m_axis_tlast_o),
    .m_axis_tready_i (m_axis_tready_i),
    .grant_o         (grant_o),
    .busy_o          (busy_o),
    .pkt_count_o     (pkt_count_o)
  );

  for (genvar g = 0; g < NCH; g++) begin : g_src
    assign s_axis_tdata_i[g*DW +: DW] = {8'(g), src_seq[g][23:0]};
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Source side: advance a channel's sequence on its own handshake.
  always @(posedge clk_i) begin
    for (int k = 0; k < NCH; k++)
      if (s_axis_tvalid_i[k] && s_axis_tready_o[k]) src_seq[k] <= src_seq[k] + 1;
  end

  // Sink side: scoreboard each accepted beat, check tlast position and
  // stability of stalled beats.
  always @(posedge clk_i) begin
    int g;
    g = int'(grant_o);
    if (stall_pend) begin
      check_eq("stall_valid", 32'(m_axis_tvalid_o), 32'd1);
      check_eq("stall_data", m_axis_tdata_o, stall_data);
    end
    stall_pend = m_axis_tvalid_o && !m_axis_tready_i;
    stall_data = m_axis_tdata_o;
    if (m_axis_tvalid_o && m_axis_tready_i) begin
      if (mon_beat == 0) grant_log.push_back(grant_o);
`ifdef PDM_ARB_CHANNEL_TAG_EN
      if (mon_beat == 0) begin
        check_eq("tag_word", m_axis_tdata_o, {8'hA5, 8'(grant_o), exp_pkt[15:0]});
      end else begin
        check_eq("data", m_axis_tdata_o, {8'(g), exp_seq[g][23:0]});
        exp_seq[g] = exp_seq[g] + 1;
      end
`else
      check_eq("data", m_axis_tdata_o, {8'(g), exp_seq[g][23:0]});
      exp_seq[g] = exp_seq[g] + 1;
`endif
      check_eq("tlast", 32'(m_axis_tlast_o), 32'(mon_beat == NW - 1));
      if (mon_beat == NW - 1) begin
        mon_beat = 0;
        exp_pkt  = exp_pkt + 1;
      end else begin
        mon_beat = mon_beat + 1;
      end
    end
    if (rst_i) begin
      mon_beat   = 0;
      exp_pkt    = 0;
      stall_pend = 1'b0;
    end
  end

  task automatic wait_pkt(input int n, input int budget);
    int i;
    i = 0;
    while (int'(pkt_count_o) != n && i < budget) begin
      @(negedge clk_i);
      i++;
    end
    check_eq("pkt_count", 32'(pkt_count_o), 32'(n));
  endtask

  task automatic wait_beat(input int n, input int budget);
    int i;
    i = 0;
    while (mon_beat != n && i < budget) begin
      @(negedge clk_i);
      i++;
    end
    check_eq("beat_reached", 32'(mon_beat), 32'(n));
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_mvalid"}, 32'(m_axis_tvalid_o), 32'd0);
    check_eq({tag, "_mlast"},  32'(m_axis_tlast_o), 32'd0);
    check_eq({tag, "_sready"}, 32'(s_axis_tready_o), 32'd0);
    check_eq({tag, "_busy"},   32'(busy_o), 32'd0);
    check_eq({tag, "_grant"},  32'(grant_o), 32'd0);
    check_eq({tag, "_pkts"},   32'(pkt_count_o), 32'd0);
  endtask

  initial begin
    rst_i           = 1'b1;
    s_axis_tvalid_i = '0;
    m_axis_tready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check_idle_outputs("reset");

    // All channels valid: round robin from channel 0.
    rst_i           = 1'b0;
    m_axis_tready_i = 1'b1;
    s_axis_tvalid_i = 4'hF;
    grant_log.delete();
    wait_pkt(5, 600);
    s_axis_tvalid_i = '0;
    check_eq("rr_log_size", 32'(grant_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++)
      check_eq("rr_grant", 32'(grant_log[i]), 32'(i % NCH));

    // Only channel 2 valid: grant 2, one bubble between back-to-back packets.
    repeat (3) @(negedge clk_i);
    s_axis_tvalid_i = 4'b0100;
    wait_pkt(6, 200);
    check_eq("ch2_grant", 32'(grant_o), 32'd2);
    check_eq("bubble_valid", 32'(m_axis_tvalid_o), 32'd0);
    check_eq("bubble_busy", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    check_eq("regrant_busy", 32'(busy_o), 32'd1);
    check_eq("regrant_grant", 32'(grant_o), 32'd2);
    wait_pkt(7, 200);
    s_axis_tvalid_i = '0;

    // Channel 1 drops valid mid-packet while channel 3 requests.
    repeat (2) @(negedge clk_i);
    s_axis_tvalid_i = 4'b0010;
    wait_beat(10, 100);
    s_axis_tvalid_i = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("gap_mvalid", 32'(m_axis_tvalid_o), 32'd0);
      check_eq("gap_sready", 32'(s_axis_tready_o), 32'b0010);
      check_eq("gap_grant", 32'(grant_o), 32'd1);
      @(negedge clk_i);
    end
    s_axis_tvalid_i = 4'b1010;
    wait_pkt(8, 200);
    check_eq("held_grant", 32'(grant_o), 32'd1);
    @(negedge clk_i);
    check_eq("next_grant", 32'(grant_o), 32'd3);
    wait_pkt(9, 200);
    s_axis_tvalid_i = '0;

    // Random back-pressure with all channels competing.
    repeat (2) @(negedge clk_i);
    s_axis_tvalid_i = 4'hF;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_i);
      if (pkt_count_o == 16'd13) break;
      m_axis_tready_i = 1'($urandom_range(0, 1));
    end
    check_eq("bp_pkts", 32'(pkt_count_o), 32'd13);
    s_axis_tvalid_i = '0;
    m_axis_tready_i = 1'b1;

    // Reset in the middle of a packet.
    repeat (2) @(negedge clk_i);
    s_axis_tvalid_i = 4'b0110;
    wait_beat(20, 100);
    check_eq("pre_rst_grant", 32'(grant_o), 32'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    check_idle_outputs("midrst");
    rst_i = 1'b0;
    s_axis_tvalid_i = 4'hF;
    grant_log.delete();
    wait_pkt(1, 200);
    check_eq("rst_log_size", 32'(grant_log.size()), 32'd1);
    check_eq("rst_first_grant", grant_log.size() > 0 ? 32'(grant_log[0]) : 32'hFF, 32'd0);
    s_axis_tvalid_i = '0;
    repeat (3) @(negedge clk_i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
